// File: rtl/pipe_pkg.sv
// Shared definitions for the writeback pipeline stage: skid-buffer state encoding
// and the default control-bundle layout (wb_sel, rf_we, wR).
package pipe_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_FULL  = 2'd1,
        SKID_SKID  = 2'd2
    } skid_state_e;

    // Default control bundle: [2:0] wb_sel, [3] rf_we, [8:4] wR
    localparam int PIPE_CTRL_W = 9;
    localparam int WB_SEL_LSB  = 0;
    localparam int WB_SEL_W    = 3;
    localparam int RF_WE_BIT   = 3;
    localparam int WR_LSB      = 4;
    localparam int WR_W        = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush, stall, bubble tagging and a bubble counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer with registered in_ready_o.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CH     = 5,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CH*DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    input  logic                 null_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CH*DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0]    ctrl_o,
    output logic                 null_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    localparam int PW = CH * DATA_W;

    logic [PW-1:0]     data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              null_q, null_d;
    logic              out_valid;
    logic              accept;
    logic              xfer;

    assign accept = in_valid_i & in_ready_o;
    assign xfer   = out_valid & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    skid_state_e       state_q, state_d;
    logic [PW-1:0]     skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              skid_null_q, skid_null_d;
    logic              ready_q, ready_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SKID_EMPTY;
            ready_q     <= 1'b1;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_null_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_null_q <= skid_null_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: if (accept) state_d = SKID_FULL;
                SKID_FULL: begin
                    if (accept && !xfer)      state_d = SKID_SKID;
                    else if (!accept && xfer) state_d = SKID_EMPTY;
                end
                SKID_SKID:  if (xfer) state_d = SKID_FULL;
                default:    state_d = SKID_EMPTY;
            endcase
        end
        ready_d = (state_d != SKID_SKID);
    end

    // Main register always holds the oldest entry; the skid slot only ever refills it.
    always_comb begin
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        null_d      = null_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_null_d = skid_null_q;
        if (flush_i) begin
            ctrl_d      = '0;
            null_d      = 1'b1;
            skid_ctrl_d = '0;
            skid_null_d = 1'b1;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        data_d = data_i;
                        ctrl_d = ctrl_i;
                        null_d = null_i;
                    end
                end
                SKID_FULL: begin
                    if (accept && xfer) begin
                        data_d = data_i;
                        ctrl_d = ctrl_i;
                        null_d = null_i;
                    end else if (accept) begin
                        skid_data_d = data_i;
                        skid_ctrl_d = ctrl_i;
                        skid_null_d = null_i;
                    end else if (xfer) begin
                        ctrl_d = '0;
                        null_d = 1'b1;
                    end
                end
                SKID_SKID: begin
                    if (xfer) begin
                        data_d      = skid_data_q;
                        ctrl_d      = skid_ctrl_q;
                        null_d      = skid_null_q;
                        skid_ctrl_d = '0;
                        skid_null_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid  = (state_q != SKID_EMPTY);
        in_ready_o = ready_q & ~stall_i & ~rst_i;
    end
`else
    logic valid_q, valid_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) valid_q <= 1'b0;
        else       valid_q <= valid_d;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        null_d  = null_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            null_d  = 1'b1;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
            null_d  = null_i;
        end else if (xfer) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            null_d  = 1'b1;
        end
    end

    always_comb begin
        out_valid  = valid_q;
        in_ready_o = ~rst_i & ~stall_i & (~valid_q | out_ready_i);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            ctrl_q <= '0;
            null_q <= 1'b1;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            null_q <= null_d;
        end
    end

    // Control is gated so an empty stage can never assert rf_we downstream.
    assign out_valid_o = out_valid;
    assign data_o      = data_q;
    assign ctrl_o      = out_valid ? ctrl_q : '0;
    assign null_o      = null_q | ~out_valid;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (~(out_valid_o & out_ready_i) | null_o),
        .cnt_o (bubble_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed scenarios plus random traffic compared
// against a queue-based reference model; a CNT_W=4 twin checks counter saturation.
module tb_pipe_stage;

    localparam int DATA_W = 32;
    localparam int CH     = 5;
    localparam int CTRL_W = 9;
    localparam int PW     = CH * DATA_W;

    logic              clk = 1'b0;
    logic              rst, in_valid, stall, flush, out_ready, null_in;
    logic [PW-1:0]     data_in;
    logic [CTRL_W-1:0] ctrl_in;

    logic              in_ready, out_valid, null_out;
    logic [PW-1:0]     data_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [15:0]       cnt16;

    logic              in_ready4, out_valid4, null_out4;
    logic [PW-1:0]     data_out4;
    logic [CTRL_W-1:0] ctrl_out4;
    logic [3:0]        cnt4;

    typedef struct {
        logic [PW-1:0]     data;
        logic [CTRL_W-1:0] ctrl;
        logic              nul;
    } entry_t;

    entry_t      model_q[$];
    int unsigned exp_cnt16;
    int unsigned exp_cnt4;
    logic        last_accept;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_stage dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_i(data_in), .ctrl_i(ctrl_in), .null_i(null_in), .stall_i(stall),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_o(data_out), .ctrl_o(ctrl_out), .null_o(null_out), .bubble_cnt_o(cnt16)
    );

    pipe_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .data_i(data_in), .ctrl_i(ctrl_in), .null_i(null_in), .stall_i(stall),
        .flush_i(flush), .out_valid_o(out_valid4), .out_ready_i(out_ready),
        .data_o(data_out4), .ctrl_o(ctrl_out4), .null_o(null_out4), .bubble_cnt_o(cnt4)
    );

    // The model is a FIFO: capacity one with combinational ready, or two with the skid slot.
    function automatic logic expReady();
`ifdef PIPE_STAGE_SKID_EN
        return !rst && !stall && (model_q.size() < 2);
`else
        return !rst && !stall && (model_q.size() == 0 || out_ready);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        logic              v;
        logic [CTRL_W-1:0] ec;
        logic              en;
        v  = (model_q.size() > 0);
        ec = v ? model_q[0].ctrl : '0;
        en = v ? model_q[0].nul : 1'b1;
        checkOutput("in_ready", PW'(in_ready), PW'(expReady()));
        checkOutput("out_valid", PW'(out_valid), PW'(v));
        checkOutput("ctrl_o", PW'(ctrl_out), PW'(ec));
        checkOutput("null_o", PW'(null_out), PW'(en));
        checkOutput("bubble_cnt", PW'(cnt16), PW'(exp_cnt16));
        checkOutput("in_ready4", PW'(in_ready4), PW'(expReady()));
        checkOutput("out_valid4", PW'(out_valid4), PW'(v));
        checkOutput("ctrl_o4", PW'(ctrl_out4), PW'(ec));
        checkOutput("null_o4", PW'(null_out4), PW'(en));
        checkOutput("bubble_cnt4", PW'(cnt4), PW'(exp_cnt4));
        if (v) begin
            checkOutput("data_o", data_out, model_q[0].data);
            checkOutput("data_o4", data_out4, model_q[0].data);
        end
    endtask

    // Drives one cycle, checks outputs before the edge, then advances the model across it.
    task automatic applyStimulus(input logic rs, input logic iv, input logic [PW-1:0] dat,
                                 input logic [CTRL_W-1:0] ctl, input logic nul, input logic stl,
                                 input logic fl, input logic ordy);
        logic   v, rdy, nul_o, inc;
        entry_t e;
        rst = rs; in_valid = iv; data_in = dat; ctrl_in = ctl;
        null_in = nul; stall = stl; flush = fl; out_ready = ordy;
        #3;
        checkAll();
        v     = (model_q.size() > 0);
        rdy   = expReady();
        nul_o = v ? model_q[0].nul : 1'b1;
        inc   = !(v && ordy) || nul_o;
        last_accept = 1'b0;
        if (rs) begin
            model_q.delete();
            exp_cnt16 = 0;
            exp_cnt4  = 0;
        end else begin
            if (inc && exp_cnt16 < 65535) exp_cnt16++;
            if (inc && exp_cnt4 < 15)     exp_cnt4++;
            if (fl) begin
                model_q.delete();
            end else begin
                if (v && ordy) void'(model_q.pop_front());
                if (iv && rdy) begin
                    e.data = dat; e.ctrl = ctl; e.nul = nul;
                    model_q.push_back(e);
                    last_accept = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rand_data();
        logic [PW-1:0] d;
        for (int k = 0; k < CH; k++) d[k*DATA_W +: DATA_W] = $urandom();
        return d;
    endfunction

    initial begin
        logic pending;
        exp_cnt16 = 0;
        exp_cnt4  = 0;
        rst = 1'b1; in_valid = 1'b1; data_in = '0; ctrl_in = '0;
        null_in = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset held two cycles with in_valid high");
        applyStimulus(1, 1, PW'(32'h77), 9'h1FF, 0, 0, 0, 1);
        checkOutput("rst_data", data_out, '0);

        $display("[TB] streaming 1,2,3");
        applyStimulus(0, 1, PW'(1), 9'h008, 0, 0, 0, 1);
        applyStimulus(0, 1, PW'(2), 9'h008, 0, 0, 0, 1);
        applyStimulus(0, 1, PW'(3), 9'h008, 0, 0, 0, 1);
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 1);

        $display("[TB] backpressure with A5 held");
        applyStimulus(0, 1, PW'(32'hA5), 9'h00F, 0, 0, 0, 0);
        pending = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, pending, PW'(32'h5A), 9'h0F0, 0, 0, 0, 0);
            if (last_accept) pending = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, pending, PW'(32'h5A), 9'h0F0, 0, 0, 0, 1);
            if (last_accept) pending = 1'b0;
        end
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 1);

        $display("[TB] flush with held and incoming entries");
        applyStimulus(0, 1, PW'(32'hF0), 9'h1FF, 0, 0, 0, 0);
        applyStimulus(0, 1, PW'(32'hBAD), 9'h1FF, 0, 0, 1, 0);
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 1);
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 1);

        $display("[TB] stall while draining, then bubble entries");
        applyStimulus(0, 1, PW'(32'h11), 9'h0AA, 0, 0, 0, 0);
        applyStimulus(0, 1, PW'(32'h22), 9'h055, 0, 1, 0, 1);
        applyStimulus(0, 1, PW'(32'h33), 9'h0FF, 1, 0, 0, 1);
        applyStimulus(0, 1, PW'(32'h44), 9'h0FF, 1, 0, 0, 1);
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(127) == 0), ($urandom_range(3) != 0), rand_data(),
                          CTRL_W'($urandom()), ($urandom_range(3) == 0),
                          ($urandom_range(7) == 0), ($urandom_range(31) == 0),
                          ($urandom_range(2) != 0));
        end

        $display("[TB] idle run for counter saturation");
        applyStimulus(1, 0, '0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, '0, '0, 0, 0, 0, 1);
        checkOutput("cnt4_saturated", PW'(cnt4), PW'(15));
        checkOutput("cnt16_idle", PW'(cnt16), PW'(20));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one payload channel.
REQ-002 SHALL have parameter CH, default 5, number of payload channels (alu_c, rd_out, pc4, pcimm, imm in the writeback use).
REQ-003 SHALL have parameter CTRL_W, default 9, control bundle width (wb_sel, rf_we, wR).
REQ-004 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-005 SHALL have ports:
 clk_i  in  1  clock; single clock domain, all state updates on rising edge.
 rst_i  in  1  synchronous, active-high reset.
 in_valid_i  in  1  upstream entry present.
 in_ready_o  out  1  stage accepts an entry this cycle.
 data_i  in  CH*DATA_W  payload, channel k at bits [k*DATA_W +: DATA_W].
 ctrl_i  in  CTRL_W  control bundle.
 null_i  in  1  entry is a bubble (no architectural effect).
 stall_i  in  1  freeze input acceptance.
 flush_i  in  1  discard all held and incoming entries.
 out_valid_o  out  1  entry presented downstream.
 out_ready_i  in  1  downstream accepts.
 data_o  out  CH*DATA_W  held payload.
 ctrl_o  out  CTRL_W  held control; all-zero whenever out_valid_o=0.
 null_o  out  1  1 when out_valid_o=0 or held entry is a bubble.
 bubble_cnt_o  out  CNT_W  saturating count of cycles with no useful output transfer.

Function
REQ-006 SHALL accept an entry when in_valid_i & in_ready_o; transfer out when out_valid_o & out_ready_i.
REQ-007 SHALL present an accepted entry on outputs exactly 1 cycle after acceptance (latency 1) when empty or draining.
REQ-008 SHALL (base build) drive in_ready_o = ~stall_i & (~out_valid_o | out_ready_i), combinational.
REQ-009 SHALL hold data_o, ctrl_o, null_o, out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-010 SHALL on simultaneous out transfer and in acceptance replace the held entry with the new one, no gap cycle.
REQ-011 SHALL on flush_i=1 at the edge: out_valid_o<=0, null_o<=1, ctrl<=0, drop any same-cycle incoming entry; data registers MAY keep stale values.
REQ-012 SHALL give flush_i priority over stall_i and acceptance; stall_i SHALL NOT block output draining.
REQ-013 SHALL force ctrl_o to zero when out_valid_o=0 so rf_we can never be asserted by an empty stage.
REQ-014 SHALL increment bubble_cnt_o each cycle where ~(out_valid_o & out_ready_i) or null_o=1, saturating at 2^CNT_W-1; flush SHALL NOT clear it.

Reset
REQ-015 SHALL on rst_i=1 at a rising edge set out_valid_o=0, data_o=0, ctrl_o=0, null_o=1, bubble_cnt_o=0, skid state empty; reset SHALL override flush_i, stall_i and handshakes.
REQ-016 SHALL drop an entry held mid-transfer when reset asserts; in_ready_o SHALL be 0 during the reset cycle.

Configuration
REQ-017 SHALL, when macro PIPE_STAGE_SKID_EN is defined, add a one-entry skid register: states EMPTY (no entry), FULL (main only), SKID (main+skid).
REQ-018 SHALL, with PIPE_STAGE_SKID_EN, drive in_ready_o from a register: 1 in EMPTY/FULL unless stall_i, 0 in SKID; no combinational path out_ready_i->in_ready_o.
REQ-019 SHALL, with PIPE_STAGE_SKID_EN, transition EMPTY->FULL on accept; FULL->SKID on accept without out transfer; SKID->FULL on out transfer (skid moves to main); FULL->EMPTY on out transfer without accept; any state->EMPTY on flush; order preserved.
REQ-020 SHALL, without PIPE_STAGE_SKID_EN, implement REQ-008 with no skid storage.

Structure
REQ-021 SHALL place skid state encoding (EMPTY/FULL/SKID) and default CTRL_W field offsets (wb_sel, rf_we, wR) in the shared package pipe_pkg.
REQ-022 SHALL implement the saturating counter as sub-module sat_counter (params CNT_W; ports clk_i, rst_i, inc_i, cnt_o).

Verification
REQ-023 Reset: rst_i=1 two cycles with in_valid_i=1 -> out_valid_o=0, null_o=1, ctrl_o=0, bubble_cnt_o=0.
REQ-024 Streaming: in_valid_i=1, out_ready_i=1, data ch0=1,2,3 on consecutive cycles -> data_o ch0=1,2,3 one cycle later, zero gap, bubble_cnt_o constant after start.
REQ-025 Backpressure: out_ready_i=0 for 4 cycles with entry 0xA5 held -> data_o=0xA5 stable; base build in_ready_o=0; skid build accepts exactly one more (0x5A) then in_ready_o=0; release -> 0xA5 then 0x5A.
REQ-026 Flush: held entry ctrl_i=9'h1FF plus incoming entry, flush_i=1 -> next cycle out_valid_o=0, ctrl_o=0, null_o=1, incoming entry never appears.
REQ-027 Stall and bubble: stall_i=1 with out_ready_i=1 -> in_ready_o=0, held entry drains; null_i=1 entries counted; CNT_W=4 run 20 idle cycles -> bubble_cnt_o=15.
